// File: rtl/wb_arbiter2.sv
// wb_arbiter2 - two-master, one-slave Wishbone arbiter.
//
// Round-robin arbitration between masters m0 and m1 onto a single slave
// port. The grant is held for the owner's whole cyc burst, and one IDLE
// cycle always separates two grants. A watchdog aborts any cycle whose
// stb has been stalled (no ack) for TIMEOUT consecutive cycles. The abort
// gives the owner a forced ack with zero read data and pulses timeout_err.
//
// The Wishbone bundles are flattened into plain ports with prefixes
// m0_, m1_ and s_.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   m0_* / m1_*             master sides:
//                             cyc, stb, we, sel, adr, wdata are inputs
//                             ack, stall, rdata are outputs
//   s_*                     slave side:
//                             cyc, stb, we, sel, adr, wdata are outputs
//                             ack, stall, rdata are inputs
//   grant                   one-hot owner, [0]=m0, [1]=m1, 00 when idle
//   timeout_err             one-cycle pulse while a cycle is being aborted
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_stall,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_stall,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_adr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    input  logic        s_stall,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1,
        ABORT
    } state_t;

    localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic          last, last_nx;      // last master granted (0 = m0, 1 = m1)
    logic [CW-1:0] wdog, wdog_nx;

    logic own_cyc;
    logic own_stb;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;             // m0 wins the first tie after reset
            wdog  <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            wdog  <= wdog_nx;
        end
    end

    // cyc/stb of whichever master currently owns the bus
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (state == GNT0) begin
            own_cyc = m0_cyc;
            own_stb = m0_stb;
        end else if (state == GNT1) begin
            own_cyc = m1_cyc;
            own_stb = m1_stb;
        end
    end

    // Next-state, round-robin and watchdog
    always_comb begin
        state_nx = state;
        last_nx  = last;
        wdog_nx  = wdog;
        case (state)
            IDLE: begin
                wdog_nx = '0;
                if (m0_cyc && (!m1_cyc || last)) begin
                    state_nx = GNT0;
                    last_nx  = 1'b0;
                end else if (m1_cyc) begin
                    state_nx = GNT1;
                    last_nx  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                // Release beats timeout; ack beats timeout.
                if (!own_cyc) begin
                    state_nx = IDLE;
                    wdog_nx  = '0;
                end else if (s_ack) begin
                    wdog_nx  = '0;
                end else if (own_stb) begin
                    if (wdog == WDOG_MAX) begin
                        state_nx = ABORT;
                        wdog_nx  = '0;
                    end else begin
                        wdog_nx  = wdog + 1'b1;
                    end
                end
            end
            ABORT: begin
                state_nx = IDLE;
                wdog_nx  = '0;
            end
            default: begin
                state_nx = IDLE;
                wdog_nx  = '0;
            end
        endcase
    end

    // Bus routing
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = '0;
        s_adr    = '0;
        s_wdata  = '0;
        m0_ack   = 1'b0;
        m0_stall = 1'b1;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_stall = 1'b1;
        m1_rdata = '0;
        case (state)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_sel    = m0_sel;
                s_adr    = m0_adr;
                s_wdata  = m0_wdata;
                m0_ack   = s_ack;
                m0_stall = s_stall;
                m0_rdata = s_rdata;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_sel    = m1_sel;
                s_adr    = m1_adr;
                s_wdata  = m1_wdata;
                m1_ack   = s_ack;
                m1_stall = s_stall;
                m1_rdata = s_rdata;
            end
            ABORT: begin
                // `last` still names the master whose cycle was aborted
                if (last) begin
                    m1_ack   = 1'b1;
                    m1_stall = 1'b0;
                end else begin
                    m0_ack   = 1'b1;
                    m0_stall = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign grant       = {state == GNT1, state == GNT0};
    assign timeout_err = (state == ABORT);

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2 (TIMEOUT = 8).
// A behavioural model tracks owner / abort / last-granted / stall count and
// a negedge process compares every output against it each cycle; directed
// sequences add literal expectations at key points.
module tb_wb_arbiter2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;

    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_wdata, m0_rdata;
    logic        m0_ack, m0_stall;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_wdata, m1_rdata;
    logic        m1_ack, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdata, s_rdata;
    logic        s_ack, s_stall;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_ack(s_ack), .s_stall(s_stall),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int own   = -1;   // current owner, -1 = nobody
    bit ab    = 1'b0; // abort cycle in progress
    int ab_m  = 0;    // master being aborted
    int mlast = 1;    // last master granted
    int cnt   = 0;    // consecutive stalled stb cycles of the owner

    function automatic logic mcyc(input int i);
        return (i == 0) ? m0_cyc : m1_cyc;
    endfunction

    function automatic logic mstb(input int i);
        return (i == 0) ? m0_stb : m1_stb;
    endfunction

    always @(posedge clk) begin
        int o, l, c;
        bit a;
        o = own; l = mlast; c = cnt; a = 1'b0;
        if (rst) begin
            o = -1; l = 1; c = 0;
        end else if (ab) begin
            o = -1; c = 0;
        end else if (own < 0) begin
            c = 0;
            if (m0_cyc && m1_cyc) o = (mlast == 1) ? 0 : 1;
            else if (m0_cyc)      o = 0;
            else if (m1_cyc)      o = 1;
            if (o >= 0) l = o;
        end else begin
            if (!mcyc(own)) begin
                o = -1; c = 0;
            end else if (s_ack) begin
                c = 0;
            end else if (mstb(own)) begin
                c = c + 1;
                if (c == TO) begin
                    a = 1'b1; o = -1; c = 0;
                end
            end
        end
        if (a) ab_m <= own;
        own   <= o;
        ab    <= a;
        mlast <= l;
        cnt   <= c;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0]  eg;
            logic        ecyc, estb, ewe;
            logic [3:0]  esel;
            logic [31:0] eadr, ewd;
            logic        ea0, es0, ea1, es1;
            logic [31:0] er0, er1;
            eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
            {ecyc, estb, ewe, esel, eadr, ewd} = '0;
            if (own == 0) {ecyc, estb, ewe, esel, eadr, ewd} = {m0_cyc, m0_stb, m0_we, m0_sel, m0_adr, m0_wdata};
            if (own == 1) {ecyc, estb, ewe, esel, eadr, ewd} = {m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_wdata};
            {ea0, es0, er0} = {1'b0, 1'b1, 32'h0};
            {ea1, es1, er1} = {1'b0, 1'b1, 32'h0};
            if (own == 0) {ea0, es0, er0} = {s_ack, s_stall, s_rdata};
            if (own == 1) {ea1, es1, er1} = {s_ack, s_stall, s_rdata};
            if (ab && ab_m == 0) {ea0, es0, er0} = {1'b1, 1'b0, 32'h0};
            if (ab && ab_m == 1) {ea1, es1, er1} = {1'b1, 1'b0, 32'h0};
            chk("grant", grant, eg);
            chk("timeout_err", timeout_err, ab);
            chk("s_cyc", s_cyc, ecyc);
            chk("s_stb", s_stb, estb);
            chk("s_we", s_we, ewe);
            chk("s_sel", s_sel, esel);
            chk("s_adr", s_adr, eadr);
            chk("s_wdata", s_wdata, ewd);
            chk("m0_bus", {m0_ack, m0_stall, m0_rdata}, {ea0, es0, er0});
            chk("m1_bus", {m1_ack, m1_stall, m1_rdata}, {ea1, es1, er1});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int i, input bit cyc, input bit stb, input bit we,
                           input logic [31:0] adr, input logic [31:0] wd);
        if (i == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_wdata = wd;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_wdata = wd;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL sim_time_limit: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0);
        drive_m(1, 0, 0, 0, 32'h0, 32'h0);
        s_ack = 1'b0; s_stall = 1'b0; s_rdata = 32'hDEADBEEF;

        tick; chk_en = 1'b1;
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_m0_stall", m0_stall, 1'b1);
        chk("rst_m1_ack", m1_ack, 1'b0);
        tick; rst = 1'b0;

        // single master read, slave acks on the third granted cycle
        drive_m(0, 1, 1, 0, 32'h100, 32'h0); s_stall = 1'b1;
        tick; #2;
        chk("single_grant", grant, 2'b01);
        chk("single_s_adr", s_adr, 32'h100);
        s_stall = 1'b0;
        tick; tick;
        s_ack = 1'b1; s_rdata = 32'hCAFEF00D; #2;
        chk("single_ack", m0_ack, 1'b1);
        chk("single_rdata", m0_rdata, 32'hCAFEF00D);
        chk("single_m1_stall", m1_stall, 1'b1);
        tick;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0; s_rdata = 32'hDEADBEEF;
        tick; #2;
        chk("single_release", grant, 2'b00);

        // tie after reset, then alternation
        rst = 1'b1; tick; rst = 1'b0;
        drive_m(0, 1, 1, 0, 32'h10, 32'h0);
        drive_m(1, 1, 1, 0, 32'h20, 32'h0);
        tick; #2;
        chk("tie_first_m0", grant, 2'b01);
        s_ack = 1'b1; tick;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0;
        tick; #2;
        chk("tie_idle_gap", grant, 2'b00);
        tick; #2;
        chk("tie_second_m1", grant, 2'b10);
        s_ack = 1'b1; tick;
        drive_m(1, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0;
        tick;
        drive_m(0, 1, 1, 0, 32'h10, 32'h0);
        drive_m(1, 1, 1, 0, 32'h20, 32'h0);
        tick; #2;
        chk("tie_alternate_m0", grant, 2'b01);
        s_ack = 1'b1; tick;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0);
        drive_m(1, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0;
        tick;

        // m1 4-beat write burst with m0 waiting
        drive_m(1, 1, 1, 1, 32'h200, 32'hB0000000);
        tick;
        drive_m(0, 1, 1, 0, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive_m(1, 1, 1, 1, 32'h200 + 32'(4 * i), 32'hB0000000 + 32'(i));
            s_ack = 1'b1; #2;
            chk("burst_grant", grant, 2'b10);
            chk("burst_wdata", s_wdata, 32'hB0000000 + 32'(i));
            chk("burst_m0_stall", m0_stall, 1'b1);
            tick;
        end
        drive_m(1, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0;
        tick; #2;
        chk("burst_gap", grant, 2'b00);
        tick; #2;
        chk("burst_m0_after2", grant, 2'b01);
        s_ack = 1'b1; tick;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0;
        tick;

        // watchdog: slave never acks
        drive_m(0, 1, 1, 0, 32'h400, 32'h0);
        tick;
        repeat (TO - 1) tick;
        #2;
        chk("wd_before", timeout_err, 1'b0);
        tick; #2;
        chk("wd_err", timeout_err, 1'b1);
        chk("wd_ack", m0_ack, 1'b1);
        chk("wd_rdata", m0_rdata, 32'h0);
        chk("wd_s_cyc", s_cyc, 1'b0);
        tick; #2;
        chk("wd_err_one_cycle", timeout_err, 1'b0);
        chk("wd_single_ack", m0_ack, 1'b0);
        tick; #2;
        chk("wd_regrant", grant, 2'b01);
        s_ack = 1'b1; tick;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0;
        tick;

        // ack arrives in the last cycle before abort
        drive_m(0, 1, 1, 0, 32'h500, 32'h0);
        tick;
        repeat (TO - 1) tick;
        s_ack = 1'b1; s_rdata = 32'h12345678; #2;
        chk("race_ack", m0_ack, 1'b1);
        chk("race_rdata", m0_rdata, 32'h12345678);
        tick;
        s_ack = 1'b0; s_rdata = 32'hDEADBEEF; #2;
        chk("race_no_err", timeout_err, 1'b0);
        chk("race_still_granted", grant, 2'b01);
        drive_m(0, 0, 0, 0, 32'h0, 32'h0);
        tick;

        // reset during m1 burst
        drive_m(1, 1, 1, 1, 32'h600, 32'h11);
        tick;
        s_ack = 1'b1; tick;
        s_ack = 1'b0; rst = 1'b1;
        tick;
        s_ack = 1'b1; #2;
        chk("rst_mid_grant", grant, 2'b00);
        chk("rst_mid_s_cyc", s_cyc, 1'b0);
        chk("rst_mid_m1_ack", m1_ack, 1'b0);
        rst = 1'b0; s_ack = 1'b0;
        drive_m(0, 1, 1, 0, 32'h700, 32'h0);
        tick; #2;
        chk("rst_tie_m0", grant, 2'b01);
        s_ack = 1'b1; tick;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0);
        drive_m(1, 0, 0, 0, 32'h0, 32'h0); s_ack = 1'b0;
        tick; tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
